// File: rtl/rans_pkg.sv
// Shared rANS constants and types used by both the encoder lanes and the decoder.
package rans_pkg;
  localparam int RANS_RESOLUTION   = 10;
  localparam int RANS_SYMBOL_WIDTH = 8;
  localparam int RANS_STATE_WIDTH  = 24;
  localparam int RANS_LEN_WIDTH    = 16;
  localparam logic [RANS_STATE_WIDTH-1:0] RANS_L =
    RANS_STATE_WIDTH'(1) << (RANS_STATE_WIDTH - RANS_SYMBOL_WIDTH);

  typedef logic [RANS_RESOLUTION:0] freq_t;
  typedef logic [RANS_RESOLUTION:0] cum_t;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SEARCH, S_EMIT, S_RENORM, S_DONE
  } dec_state_t;
endpackage

// File: rtl/rans_dec_tbl.sv
// Symbol table: NSYM x (freq, cum) registers, one write port, two combinational read ports.
module rans_dec_tbl #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int FW           = 11
) (
  input  logic                    clk_i,
  input  logic                    wr_en,
  input  logic [SYMBOL_WIDTH-1:0] wr_addr,
  input  logic [FW-1:0]           wr_freq,
  input  logic [FW-1:0]           wr_cum,
  input  logic [SYMBOL_WIDTH-1:0] probe_addr,
  output logic [FW-1:0]           probe_cum,
  input  logic [SYMBOL_WIDTH-1:0] sel_addr,
  output logic [FW-1:0]           sel_freq,
  output logic [FW-1:0]           sel_cum
);
  localparam int NSYM = 1 << SYMBOL_WIDTH;

  logic [NSYM-1:0][FW-1:0] freq_q;
  logic [NSYM-1:0][FW-1:0] cum_q;

  // Contents survive reset so a table can be reused across aborted frames.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      freq_q[wr_addr] <= wr_freq;
      cum_q[wr_addr]  <= wr_cum;
    end
  end

  assign probe_cum = cum_q[probe_addr];
  assign sel_freq  = freq_q[sel_addr];
  assign sel_cum   = cum_q[sel_addr];
endmodule

// File: rtl/rans_dec.sv
// Single-lane rANS decoder: reversed encoder byte stream in, symbols out on valid/ready.
module rans_dec
  import rans_pkg::*;
#(
  parameter int RESOLUTION   = RANS_RESOLUTION,
  parameter int SYMBOL_WIDTH = RANS_SYMBOL_WIDTH,
  parameter int STATE_WIDTH  = RANS_STATE_WIDTH,
  parameter int LEN_WIDTH    = RANS_LEN_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
  input  logic [RESOLUTION:0]     freq_i,
  input  logic [RESOLUTION:0]     cum_freq_i,
  output logic                    ready_o,
  input  logic                    start_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic                    in_valid_i,
  input  logic [SYMBOL_WIDTH-1:0] in_byte_i,
  output logic                    in_ready_o,
  output logic                    sym_valid_o,
  output logic [SYMBOL_WIDTH-1:0] sym_o,
  input  logic                    sym_ready_i,
  output logic                    done_o,
  output logic                    state_ok_o
);
  localparam int FW     = RESOLUTION + 1;
  localparam int NBYTES = STATE_WIDTH / SYMBOL_WIDTH;
  localparam int BW     = (SYMBOL_WIDTH > 1) ? $clog2(SYMBOL_WIDTH) : 1;
  localparam int CW     = $clog2(NBYTES) + 1;
  localparam logic [STATE_WIDTH-1:0] LOW =
    STATE_WIDTH'(1) << (STATE_WIDTH - SYMBOL_WIDTH);

  dec_state_t              state_q, state_d;
  logic [STATE_WIDTH-1:0]  x_q, x_dec, x_shift;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic [SYMBOL_WIDTH-1:0] sym_q, probe;
  logic [BW-1:0]           bit_q;
  logic [CW-1:0]           byte_q;
  logic                    ok_q;
  logic [FW-1:0]           probe_cum, sel_freq, sel_cum;
  logic [RESOLUTION-1:0]   slot;
  logic                    x_low, last_byte, hit;

  rans_dec_tbl #(.SYMBOL_WIDTH(SYMBOL_WIDTH), .FW(FW)) u_tbl (
    .clk_i      (clk_i),
    .wr_en      (freq_wr_i && (state_q == S_IDLE)),
    .wr_addr    (freq_addr_i),
    .wr_freq    (freq_i),
    .wr_cum     (cum_freq_i),
    .probe_addr (probe),
    .probe_cum  (probe_cum),
    .sel_addr   (sym_q),
    .sel_freq   (sel_freq),
    .sel_cum    (sel_cum)
  );

  assign slot      = x_q[RESOLUTION-1:0];
  // Binary search: try setting the current bit, keep it if cum[probe] still fits under slot.
  assign probe     = sym_q | (SYMBOL_WIDTH'(1) << bit_q);
  assign hit       = probe_cum <= FW'(slot);
  assign x_low     = x_q < LOW;
  assign x_shift   = {x_q[STATE_WIDTH-SYMBOL_WIDTH-1:0], in_byte_i};
  assign last_byte = byte_q == CW'(NBYTES - 1);
  assign x_dec     = STATE_WIDTH'(sel_freq) * (x_q >> RESOLUTION)
                   + STATE_WIDTH'(slot) - STATE_WIDTH'(sel_cum);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    in_ready_o  = 1'b0;
    sym_valid_o = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_d = (len_i == '0) ? S_DONE : S_INIT;
      end
      S_INIT: begin
        in_ready_o = 1'b1;
        if (in_valid_i && last_byte) state_d = S_SEARCH;
      end
      S_SEARCH: if (bit_q == '0) state_d = S_EMIT;
      S_EMIT: begin
        sym_valid_o = 1'b1;
        if (sym_ready_i) state_d = S_RENORM;
      end
      S_RENORM: begin
        if (x_low)             in_ready_o = 1'b1;
        else if (rem_q != '0)  state_d = S_SEARCH;
        else                   state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      rem_q  <= '0;
      sym_q  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      ok_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          rem_q  <= len_i;
          ok_q   <= 1'b0;
          // An empty frame leaves x at the bound so it reports a clean final state.
          x_q    <= LOW;
          byte_q <= '0;
        end
        S_INIT: if (in_valid_i) begin
          x_q    <= x_shift;
          byte_q <= byte_q + CW'(1);
          if (last_byte) begin
            sym_q <= '0;
            bit_q <= BW'(SYMBOL_WIDTH - 1);
          end
        end
        S_SEARCH: begin
          if (hit) sym_q <= probe;
          bit_q <= bit_q - BW'(1);
        end
        S_EMIT: if (sym_ready_i) begin
          x_q   <= x_dec;
          rem_q <= rem_q - LEN_WIDTH'(1);
        end
        S_RENORM: begin
          if (x_low) begin
            if (in_valid_i) x_q <= x_shift;
          end else begin
            sym_q <= '0;
            bit_q <= BW'(SYMBOL_WIDTH - 1);
          end
        end
        S_DONE: ok_q <= (x_q == LOW);
        default: ;
      endcase
    end
  end

  assign sym_o      = sym_q;
  assign state_ok_o = ok_q;
endmodule

// File: tb/tb_rans_dec.sv
// Scoreboard bench for rans_dec: directed frames plus random tables/frames built by an rANS encoder model.
module tb_rans_dec;
  typedef struct { bit ok; int left; } done_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        freq_wr_i;
  logic [7:0]  freq_addr_i;
  logic [10:0] freq_i, cum_freq_i;
  logic        ready_o, start_i;
  logic [15:0] len_i;
  logic        in_valid_i;
  logic [7:0]  in_byte_i;
  logic        in_ready_o, sym_valid_o;
  logic [7:0]  sym_o;
  logic        sym_ready_i, done_o, state_ok_o;

  always #5 clk_i = ~clk_i;

  rans_dec dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .freq_wr_i(freq_wr_i), .freq_addr_i(freq_addr_i),
    .freq_i(freq_i), .cum_freq_i(cum_freq_i), .ready_o(ready_o), .start_i(start_i),
    .len_i(len_i), .in_valid_i(in_valid_i), .in_byte_i(in_byte_i), .in_ready_o(in_ready_o),
    .sym_valid_o(sym_valid_o), .sym_o(sym_o), .sym_ready_i(sym_ready_i), .done_o(done_o),
    .state_ok_o(state_ok_o)
  );

  int n_vec = 0, n_err = 0;
  int exp_sym[$];
  done_t exp_done[$];
  logic [7:0] bq[$];
  int done_cnt = 0, stall_cnt = 0, gap_len = 0, hold_cnt = 0;
  bit rand_gap = 0, rand_rdy = 0, no_inready = 0;
  int tf[256], tc[256];
  int act_syms[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Byte source: presents bq[0], pops it on a handshake, optional gaps after each byte.
  initial begin
    bit fire;
    int gcnt;
    gcnt = 0;
    in_valid_i = 1'b0;
    in_byte_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      fire = in_valid_i && in_ready_o && rst_ni;
      @(posedge clk_i);
      #1;
      if (fire && bq.size() > 0) begin
        void'(bq.pop_front());
        gcnt = gap_len;
      end
      if (gcnt > 0) begin
        in_valid_i = 1'b0;
        gcnt--;
      end else if (bq.size() > 0 && (!rand_gap || $urandom_range(0, 1) == 1)) begin
        in_valid_i = 1'b1;
        in_byte_i  = bq[0];
      end else begin
        in_valid_i = 1'b0;
      end
    end
  end

  // Symbol sink: optional forced stall of hold_cnt valid cycles, else always/randomly ready.
  initial begin
    sym_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (hold_cnt > 0) begin
        sym_ready_i = 1'b0;
        if (sym_valid_o) hold_cnt--;
      end else begin
        sym_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: compares every presented symbol and every frame end against the queues.
  initial begin
    done_t d;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) continue;
      if (no_inready) chk("in_ready_empty_frame", in_ready_o, 0);
      if (sym_valid_o) begin
        if (exp_sym.size() == 0) chk("unexpected_sym", 1, 0);
        else begin
          chk("sym", sym_o, exp_sym[0]);
          chk("in_ready_during_emit", in_ready_o, 0);
          if (sym_ready_i) begin
            act_syms.push_back(int'(sym_o));
            void'(exp_sym.pop_front());
          end else stall_cnt++;
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("bytes_left_at_done", bq.size(), d.left);
          chk("syms_pending_at_done", exp_sym.size(), 0);
          @(negedge clk_i);
          chk("state_ok", state_ok_o, d.ok);
          chk("done_one_cycle", done_o, 0);
        end
        done_cnt++;
      end
    end
  end

  task automatic load_table();
    for (int s = 0; s < 256; s++) begin
      @(negedge clk_i);
      freq_wr_i = 1'b1; freq_addr_i = 8'(s); freq_i = 11'(tf[s]); cum_freq_i = 11'(tc[s]);
    end
    @(negedge clk_i);
    freq_wr_i = 1'b0;
  endtask

  task automatic do_start(input int len);
    int t;
    t = 0;
    @(negedge clk_i);
    while (!ready_o && t < 2000) begin @(negedge clk_i); t++; end
    if (!ready_o) chk("ready_timeout", 0, 1);
    start_i = 1'b1; len_i = 16'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic run_frame(input int len, input int syms[$], input logic [7:0] bytes[$],
                           input int left, input bit ok, input bit busy_wr);
    int t, c0;
    foreach (syms[i]) exp_sym.push_back(syms[i]);
    exp_done.push_back('{ok, left});
    foreach (bytes[i]) bq.push_back(bytes[i]);
    c0 = done_cnt;
    do_start(len);
    if (busy_wr) begin
      freq_wr_i = 1'b1; freq_addr_i = 8'd1; freq_i = 11'd0; cum_freq_i = 11'd0;
      repeat (3) @(posedge clk_i);
      #1 freq_wr_i = 1'b0;
    end
    t = 0;
    while (done_cnt == c0 && t < 20000) begin @(negedge clk_i); t++; end
    if (done_cnt == c0) begin
      chk("frame_timeout", 0, 1);
      exp_sym.delete(); exp_done.delete();
    end
    bq.delete();
  endtask

  // Reference rANS encoder; returns bytes in decoder order (reverse of emission).
  task automatic encode(input int syms[$], output logic [7:0] stream[$]);
    int unsigned x, f, xmax;
    logic [7:0] em[$];
    x = 32'h10000;
    for (int i = syms.size() - 1; i >= 0; i--) begin
      f = tf[syms[i]];
      xmax = 16384 * f;
      while (x >= xmax) begin em.push_back(8'(x % 256)); x = x / 256; end
      x = (x / f) * 1024 + (x % f) + tc[syms[i]];
    end
    for (int k = 0; k < 3; k++) begin em.push_back(8'(x % 256)); x = x / 256; end
    stream.delete();
    for (int i = em.size() - 1; i >= 0; i--) stream.push_back(em[i]);
  endtask

  initial begin
    int syms[$], used[$], n, len;
    logic [7:0] bytes[$];
    rst_ni = 1'b0; freq_wr_i = 1'b0; freq_addr_i = '0; freq_i = '0; cum_freq_i = '0;
    start_i = 1'b0; len_i = '0;
    #1;
    chk("rst_ready", ready_o, 1); chk("rst_in_ready", in_ready_o, 0);
    chk("rst_sym_valid", sym_valid_o, 0); chk("rst_sym", sym_o, 0);
    chk("rst_done", done_o, 0); chk("rst_state_ok", state_ok_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int s = 0; s < 256; s++) begin tf[s] = 0; tc[s] = 1024; end
    tf[0] = 512; tc[0] = 0; tf[1] = 256; tc[1] = 512; tf[2] = 256; tc[2] = 768;
    load_table();

    // Empty frame: immediate done, never requests a byte, clean final state.
    no_inready = 1;
    syms = {}; bytes = {};
    run_frame(0, syms, bytes, 0, 1, 0);
    no_inready = 0;

    // Symbol 0 lands exactly on L; the trailing byte must stay unread.
    syms = {0}; bytes = {8'h02, 8'h00, 8'h00, 8'hAA};
    run_frame(1, syms, bytes, 1, 1, 0);

    // Symbol 1 needs one renorm byte; final x = 0x400000.
    syms = {1}; bytes = {8'h01, 8'h02, 8'h00, 8'h00};
    run_frame(1, syms, bytes, 0, 0, 0);

    // Downstream stall of 5 cycles.
    stall_cnt = 0; hold_cnt = 5;
    syms = {0}; bytes = {8'h02, 8'h00, 8'h00, 8'hAA};
    run_frame(1, syms, bytes, 1, 1, 0);
    chk("stall_cycles", stall_cnt, 5);

    // Input gaps of 3 cycles, with table writes attempted mid-frame.
    gap_len = 3;
    syms = {1}; bytes = {8'h01, 8'h02, 8'h00, 8'h00};
    run_frame(1, syms, bytes, 0, 0, 1);
    gap_len = 0;

    // Reset while sitting in RENORM waiting for a byte.
    exp_sym.push_back(1);
    bq = {8'h01, 8'h02, 8'h00};
    do_start(1);
    n = 0;
    while (exp_sym.size() != 0 && n < 200) begin @(negedge clk_i); n++; end
    chk("sym_before_reset", exp_sym.size(), 0);
    @(posedge clk_i); #2;
    chk("renorm_requests_byte", in_ready_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1); chk("arst_in_ready", in_ready_o, 0);
    @(posedge clk_i); #1;
    chk("arst_ready_next", ready_o, 1); chk("arst_in_ready_next", in_ready_o, 0);
    chk("arst_sym_valid", sym_valid_o, 0); chk("arst_done", done_o, 0);
    bq.delete(); exp_sym.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Table must survive both the busy writes and the reset.
    syms = {1}; bytes = {8'h01, 8'h02, 8'h00, 8'h00};
    run_frame(1, syms, bytes, 0, 0, 0);

    // Random tables and frames through the reference encoder.
    for (int t = 0; t < 4; t++) begin
      used.delete();
      n = $urandom_range(1, 12);
      for (int s = 0; s < 256; s++) tf[s] = 0;
      for (int i = 0; i < n; i++) begin
        used.push_back(t == 3 && i == 0 ? 255 : $urandom_range(0, 255));
        tf[used[i]]++;
      end
      for (int u = 0; u < 1024 - n; u++) tf[used[$urandom_range(0, n - 1)]]++;
      len = 0;
      for (int s = 0; s < 256; s++) begin tc[s] = len; len += tf[s]; end
      load_table();
      for (int f = 0; f < 5; f++) begin
        rand_gap = ($urandom_range(0, 1) == 1);
        rand_rdy = ($urandom_range(0, 1) == 1);
        len = $urandom_range(1, 40);
        syms.delete();
        for (int i = 0; i < len; i++) syms.push_back(used[$urandom_range(0, n - 1)]);
        encode(syms, bytes);
        act_syms.delete();
        run_frame(len, syms, bytes, 0, 1, 0);
        chk("frame_sym_count", act_syms.size(), len);
      end
    end
    rand_gap = 0; rand_rdy = 0;
    repeat (4) @(negedge clk_i);
    chk("no_pending_done", exp_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
